seq_run_ctrl: RTL and testbench

- Owns architectural PC and Y86-64 status (Stat) for the SEQ processor; replaces free-running PC reassignment with a controlled run/step/halt sequencer.
- Drives a commit strobe that gates register-file, condition-code and data-memory writes in decode/execute/memory.
- Adds single-step, breakpoint pause, fault latching with Y86 Stat codes, and saturating cycle/instruction counters.
- Parametrised in address width, reset vector and counter width.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/seq_run_ctrl_if.sv | 38 +++
 rtl/sat_counter.sv | 38 +++
 rtl/seq_run_ctrl.sv | 137 +++++++++++++
 tb/tb_seq_run_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg
// Shared Y86-64 definitions for the SEQ processor:
//   - Stat codes reported on the status output
//   - run-state encoding used by the run/step/halt sequencer
//   - instruction codes used by fetch and pc_update
package y86_pkg;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } run_state_e;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   function automatic logic is_exec_state(run_state_e s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/seq_run_ctrl_if.sv
// seq_run_ctrl_if
// Bundles the sequencer's control, pipeline-feedback and status signals.
//   slave  : seen by seq_run_ctrl (control/feedback in, pc/commit/status out)
//   master : seen by the host / surrounding SEQ stages
interface seq_run_ctrl_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
);
   logic              start;
   logic              step;
   logic              restart;
   logic              bkpt_en;
   logic [ADDR_W-1:0] bkpt_addr;
   logic [ADDR_W-1:0] next_pc;
   logic              imem_error;
   logic              invalid_instr;
   logic              dmem_error;
   logic              halt;
   logic [ADDR_W-1:0] pc;
   logic              commit;
   logic [2:0]        stat;
   logic              all_ok;
   logic              running;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  instr_count;

   modport slave (
      input  start, step, restart, bkpt_en, bkpt_addr, next_pc,
             imem_error, invalid_instr, dmem_error, halt,
      output pc, commit, stat, all_ok, running, cycle_count, instr_count
   );

   modport master (
      output start, step, restart, bkpt_en, bkpt_addr, next_pc,
             imem_error, invalid_instr, dmem_error, halt,
      input  pc, commit, stat, all_ok, running, cycle_count, instr_count
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, async active-low reset (clears count)
//   en         : count this clock
//   clr        : synchronous clear, wins over en
//   count      : current value
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl
// Run/step/halt sequencer for the SEQ processor. Owns the architectural PC
// and Y86 Stat, produces the commit strobe that gates every state write in
// decode/execute/memory, and keeps saturating cycle/instruction counters.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_run_ctrl_if.slave (control in, pipeline feedback in,
//                pc/commit/status/counters out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | paused; waiting for start or step
// ST_RUN    | executing one instruction per clock until fault/halt/bkpt
// ST_STEP   | executing exactly one instruction, then back to IDLE
// ST_HALTED | Stat latched (HLT/ADR/INS); only restart leaves
module seq_run_ctrl
   import y86_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input logic          clk,
   input logic          rst_n,
   seq_run_ctrl_if.slave bus
);
   run_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        stat_q, stat_d;
   logic              skip_q, skip_d;

   logic       in_exec;
   logic       bkpt_hit;
   logic       commit;
   logic       stop;
   logic [2:0] stop_code;
   logic       instr_inc;
   logic       cnt_clr;

   assign in_exec = is_exec_state(state_q);
   // skip_q masks the breakpoint on the first RUN cycle so a paused program
   // can resume from the breakpoint PC.
   assign bkpt_hit = bus.bkpt_en && (pc_q == bus.bkpt_addr) &&
                     (state_q == ST_RUN) && !skip_q;
   assign commit = in_exec && !bkpt_hit;

   always_comb begin
      stop      = 1'b1;
      stop_code = STAT_AOK;
      if (bus.imem_error) begin
         stop_code = STAT_ADR;
      end else if (bus.invalid_instr) begin
         stop_code = STAT_INS;
      end else if (bus.dmem_error) begin
         stop_code = STAT_ADR;
      end else if (bus.halt) begin
         stop_code = STAT_HLT;
      end else begin
         stop = 1'b0;
      end
   end

   // halt retires as an instruction; address/instruction faults do not.
   assign instr_inc = commit && !(bus.imem_error || bus.invalid_instr || bus.dmem_error);
   assign cnt_clr   = (state_q == ST_HALTED) && bus.restart;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stat_d  = stat_q;
      skip_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end else if (bus.step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN, ST_STEP: begin
            if (bkpt_hit) begin
               state_d = ST_IDLE;
            end else if (stop) begin
               stat_d  = stop_code;
               state_d = ST_HALTED;
            end else begin
               pc_d = bus.next_pc;
               if (state_q == ST_STEP) state_d = ST_IDLE;
            end
         end
         ST_HALTED: begin
            if (bus.restart) begin
               pc_d    = RESET_PC;
               stat_d  = STAT_AOK;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         stat_q  <= STAT_AOK;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
         skip_q  <= skip_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_exec),
      .clr   (cnt_clr),
      .count (bus.cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (instr_inc),
      .clr   (cnt_clr),
      .count (bus.instr_count)
   );

   assign bus.pc      = pc_q;
   assign bus.commit  = commit;
   assign bus.running = commit;
   assign bus.stat    = stat_q;
   assign bus.all_ok  = (stat_q == STAT_AOK);
endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb_seq_run_ctrl
// Directed bench for seq_run_ctrl: a 32-bit-counter instance and a 4-bit
// counter instance share the same stimulus.
module tb_seq_run_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, step = 1'b0, restart = 1'b0, bkpt_en = 1'b0;
   logic [63:0] bkpt_addr = '0, next_pc = '0;
   logic        imem_error = 1'b0, invalid_instr = 1'b0, dmem_error = 1'b0, halt = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_run_ctrl_if #(.ADDR_W(64), .CNT_W(32)) bus ();
   seq_run_ctrl_if #(.ADDR_W(64), .CNT_W(4))  bus4 ();

   assign bus.start = start;          assign bus4.start = start;
   assign bus.step = step;            assign bus4.step = step;
   assign bus.restart = restart;      assign bus4.restart = restart;
   assign bus.bkpt_en = bkpt_en;      assign bus4.bkpt_en = bkpt_en;
   assign bus.bkpt_addr = bkpt_addr;  assign bus4.bkpt_addr = bkpt_addr;
   assign bus.next_pc = next_pc;      assign bus4.next_pc = next_pc;
   assign bus.imem_error = imem_error;        assign bus4.imem_error = imem_error;
   assign bus.invalid_instr = invalid_instr;  assign bus4.invalid_instr = invalid_instr;
   assign bus.dmem_error = dmem_error;        assign bus4.dmem_error = dmem_error;
   assign bus.halt = halt;            assign bus4.halt = halt;

   seq_run_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seq_run_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1; tick(); restart = 1'b0;
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_pc", bus.pc, 0);
      chk("rst_stat", bus.stat, 1);
      chk("rst_commit", bus.commit, 0);
      chk("rst_running", bus.running, 0);
      chk("rst_all_ok", bus.all_ok, 1);
      chk("rst_cycles", bus.cycle_count, 0);
      chk("rst_instrs", bus.instr_count, 0);
      rst_n = 1'b1;
      tick();

      // run 0 -> 10 -> 20 -> 30
      pulse_start();
      chk("run_commit0", bus.commit, 1);
      next_pc = 10; tick();
      next_pc = 20; tick();
      next_pc = 30; tick();
      chk("run_pc", bus.pc, 30);
      chk("run_stat", bus.stat, 1);
      chk("run_instrs", bus.instr_count, 3);
      chk("run_cycles", bus.cycle_count, 3);
      chk("run_all_ok", bus.all_ok, 1);

      // halt at pc 30
      halt = 1'b1; tick(); halt = 1'b0;
      chk("hlt_stat", bus.stat, 2);
      chk("hlt_pc", bus.pc, 30);
      chk("hlt_instrs", bus.instr_count, 4);
      chk("hlt_cycles", bus.cycle_count, 4);
      chk("hlt_commit", bus.commit, 0);
      chk("hlt_all_ok", bus.all_ok, 0);
      pulse_start();
      chk("hlt_start_ign_pc", bus.pc, 30);
      chk("hlt_start_ign_commit", bus.commit, 0);
      chk("hlt_start_ign_cyc", bus.cycle_count, 4);
      pulse_restart();
      chk("rs_pc", bus.pc, 0);
      chk("rs_stat", bus.stat, 1);
      chk("rs_cycles", bus.cycle_count, 0);
      chk("rs_instrs", bus.instr_count, 0);
      chk("rs_running", bus.running, 0);

      // single step
      next_pc = 10;
      step = 1'b1; tick(); step = 1'b0;
      chk("step_commit", bus.commit, 1);
      tick();
      chk("step_pc", bus.pc, 10);
      chk("step_instrs", bus.instr_count, 1);
      chk("step_commit_after", bus.commit, 0);
      tick();
      chk("step_pc_hold", bus.pc, 10);
      chk("step_cycles", bus.cycle_count, 1);

      // async reset mid-run
      pulse_start();
      next_pc = 20; tick();
      chk("pre_rst_pc", bus.pc, 20);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", bus.pc, 0);
      chk("arst_stat", bus.stat, 1);
      chk("arst_cycles", bus.cycle_count, 0);
      chk("arst_instrs", bus.instr_count, 0);
      chk("arst_commit", bus.commit, 0);
      tick(); rst_n = 1'b1; tick();

      // fault priority: invalid_instr over dmem_error at pc 20
      pulse_start();
      next_pc = 10; tick();
      next_pc = 20; tick();
      invalid_instr = 1'b1; dmem_error = 1'b1; next_pc = 30;
      chk("flt_commit", bus.commit, 1);
      tick();
      invalid_instr = 1'b0; dmem_error = 1'b0;
      chk("flt_stat", bus.stat, 4);
      chk("flt_pc", bus.pc, 20);
      chk("flt_commit_after", bus.commit, 0);
      chk("flt_instrs", bus.instr_count, 2);
      chk("flt_cycles", bus.cycle_count, 3);
      pulse_start();
      chk("flt_start_ign", bus.commit, 0);
      pulse_restart();
      chk("flt_rs_pc", bus.pc, 0);
      chk("flt_rs_stat", bus.stat, 1);
      chk("flt_rs_cycles", bus.cycle_count, 0);

      // imem_error and dmem_error -> ADR
      pulse_start();
      dmem_error = 1'b1; tick(); dmem_error = 1'b0;
      chk("adr_stat", bus.stat, 3);
      chk("adr_instrs", bus.instr_count, 0);
      pulse_restart();
      pulse_start();
      imem_error = 1'b1; halt = 1'b1; tick(); imem_error = 1'b0; halt = 1'b0;
      chk("adr_imem_stat", bus.stat, 3);
      chk("adr_imem_instrs", bus.instr_count, 0);
      pulse_restart();

      // breakpoint at 20
      bkpt_en = 1'b1; bkpt_addr = 20;
      pulse_start();
      next_pc = 10; tick();
      next_pc = 20; tick();
      chk("bk_pc", bus.pc, 20);
      chk("bk_commit", bus.commit, 0);
      chk("bk_running", bus.running, 0);
      tick();
      chk("bk_pc_hold", bus.pc, 20);
      chk("bk_idle_commit", bus.commit, 0);
      chk("bk_cycles", bus.cycle_count, 3);
      chk("bk_instrs", bus.instr_count, 2);
      pulse_start();
      chk("bk_resume_commit", bus.commit, 1);
      next_pc = 30; tick();
      chk("bk_resume_pc", bus.pc, 30);
      chk("bk_resume_instrs", bus.instr_count, 3);
      halt = 1'b1; tick(); halt = 1'b0;
      chk("bk_halt_stat", bus.stat, 2);
      pulse_restart();
      bkpt_en = 1'b0;

      // saturation: 20 RUN cycles
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         next_pc = 64'(8 * (i + 1));
         tick();
      end
      chk("sat4_cycles", bus4.cycle_count, 15);
      chk("sat4_instrs", bus4.instr_count, 15);
      chk("sat32_cycles", bus.cycle_count, 20);
      chk("sat32_instrs", bus.instr_count, 20);
      chk("sat_pc", bus.pc, 160);
      tick();
      chk("sat4_hold", bus4.cycle_count, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
